// File: rtl/fetch_ctrl.sv
// PC sequencer for the dual-issue front end: issues one 8-byte bundle fetch per
// cycle, packs {instr1, pc1, instr0, pc0} into the fetch FIFO, handles jump redirects.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         jump,
    input  logic [31:0]  jump_addr,
    output logic         jump_accept,
    input  logic         stop_fetch,
    output logic         imem_req,
    output logic [31:0]  imem_addr,
    input  logic [63:0]  imem_rdata,
    output logic [127:0] fetch_instr_pc,
    output logic         write_fifo
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_STALL    = 2'd2;
    localparam logic [1:0] ST_REDIRECT = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        inflight_q, inflight_d;
    logic        odd_slot_q, odd_slot_d;
    logic        jump_accept_q, jump_accept_d;

    logic        jump_take;
    logic        issue;
    logic        push;
    logic        unused_jump_lsb;

    // Word-offset bits of the target never influence the bundle address.
    assign unused_jump_lsb = ^jump_addr[1:0];

    always_comb begin
        // The cycle right after an accepted jump ignores a still-held jump.
        jump_take     = jump && (state_q != ST_REDIRECT);
        issue         = (state_q != ST_IDLE) && !jump_take && !stop_fetch;
        push          = inflight_q && !jump_take;

        state_d       = state_q;
        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        inflight_d    = issue;
        odd_slot_d    = odd_slot_q;
        jump_accept_d = jump_take;

        if (issue) begin
            pc_d     = pc_q + 32'd8;
            req_pc_d = pc_q;
        end

        if (push) begin
            odd_slot_d = 1'b0;
        end

        if (jump_take) begin
            pc_d       = {jump_addr[31:3], 3'b000};
            odd_slot_d = jump_addr[2];
            state_d    = ST_REDIRECT;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_RUN;
                default:  state_d = stop_fetch ? ST_STALL : ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            req_pc_q      <= RESET_PC;
            inflight_q    <= 1'b0;
            odd_slot_q    <= 1'b0;
            jump_accept_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_pc_q      <= req_pc_d;
            inflight_q    <= inflight_d;
            odd_slot_q    <= odd_slot_d;
            jump_accept_q <= jump_accept_d;
        end
    end

    always_comb begin
        imem_req       = issue;
        imem_addr      = pc_q;
        jump_accept    = jump_accept_q;
        write_fifo     = push;
        fetch_instr_pc = '0;
        if (push) begin
            fetch_instr_pc = {imem_rdata[63:32],
                              req_pc_q + 32'd4,
                              odd_slot_q ? NOP_INSTR : imem_rdata[31:0],
                              req_pc_q};
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a cycle-level reference model checked every
// cycle, plus literal expectations at key points of each scenario.
module tb_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         jump;
    logic [31:0]  jump_addr;
    logic         jump_accept;
    logic         stop_fetch;
    logic         imem_req;
    logic [31:0]  imem_addr;
    logic [63:0]  imem_rdata;
    logic [127:0] fetch_instr_pc;
    logic         write_fifo;

    always #5 clk = ~clk;

    fetch_ctrl #(
        .RESET_PC  (RST_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .jump           (jump),
        .jump_addr      (jump_addr),
        .jump_accept    (jump_accept),
        .stop_fetch     (stop_fetch),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .fetch_instr_pc (fetch_instr_pc),
        .write_fifo     (write_fifo)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk1(input string name, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic chk128(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Memory stand-in: a request seen in one cycle is answered the next.
    logic        last_req;
    logic [31:0] last_addr;
    logic [63:0] mask = '0;

    always @(negedge clk) begin
        last_req  = imem_req;
        last_addr = imem_addr;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        imem_rdata = last_req ? ({last_addr + 32'd4, last_addr} ^ mask) : {$urandom, $urandom};
    endtask

    // Reference model: a fetch happens every cycle unless stalled, just out of
    // reset, or a jump is taken; a taken jump kills the pending response and
    // blocks jump recognition for the following cycle.
    logic         m_first, m_pend, m_odd, m_acc, m_cool;
    logic [31:0]  m_pc, m_ppc;
    logic         jt, e_req, e_wr, e_acc;
    logic [31:0]  e_addr;
    logic [127:0] e_fip;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_first = 1'b1; m_pend = 1'b0; m_odd = 1'b0; m_acc = 1'b0; m_cool = 1'b0;
            m_pc    = RST_PC; m_ppc = RST_PC;
            e_req = 1'b0; e_wr = 1'b0; e_acc = 1'b0; e_addr = RST_PC; e_fip = '0;
        end else begin
            jt     = jump && !m_cool;
            e_wr   = m_pend && !jt;
            e_req  = !m_first && !stop_fetch && !jt;
            e_acc  = m_acc;
            e_addr = m_pc;
            e_fip  = e_wr ? {imem_rdata[63:32], m_ppc + 32'd4,
                             m_odd ? NOP : imem_rdata[31:0], m_ppc} : '0;
        end

        chk1  ("cyc_imem_req",    imem_req,       e_req);
        chk32 ("cyc_imem_addr",   imem_addr,      e_addr);
        chk1  ("cyc_write_fifo",  write_fifo,     e_wr);
        chk1  ("cyc_jump_accept", jump_accept,    e_acc);
        chk128("cyc_fetch_word",  fetch_instr_pc, e_fip);

        if (rst_n) begin
            m_pend = e_req;
            if (e_req) m_ppc = m_pc;
            if (jt) begin
                m_pc  = {jump_addr[31:3], 3'b000};
                m_odd = jump_addr[2];
            end else begin
                if (e_req) m_pc = m_pc + 32'd8;
                if (e_wr)  m_odd = 1'b0;
            end
            m_acc   = jt;
            m_cool  = jt;
            m_first = 1'b0;
        end
    end

    logic [1:0] pat [16];

    initial begin
        rst_n = 1'b1; jump = 1'b0; stop_fetch = 1'b0; jump_addr = '0; imem_rdata = '0;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        #2;
        chk1  ("rst_write_fifo",  write_fifo, 1'b0);
        chk1  ("rst_jump_accept", jump_accept, 1'b0);
        chk1  ("rst_imem_req",    imem_req, 1'b0);
        chk128("rst_fetch_word",  fetch_instr_pc, '0);
        chk32 ("rst_imem_addr",   imem_addr, RST_PC);

        // Streaming from reset
        tick(); rst_n = 1'b1; #2;
        chk1("idle_no_req", imem_req, 1'b0);
        tick(); #2;
        chk1 ("c1_req", imem_req, 1'b1);
        chk32("c1_addr", imem_addr, 32'h0);
        chk1 ("c1_no_push", write_fifo, 1'b0);
        tick(); #2;
        chk32 ("c2_addr", imem_addr, 32'h8);
        chk1  ("c2_push", write_fifo, 1'b1);
        chk128("c2_word", fetch_instr_pc, {32'h4, 32'h4, 32'h0, 32'h0});
        tick(); #2; chk32("c3_addr", imem_addr, 32'h10);
        tick(); #2; chk32("c4_addr", imem_addr, 32'h18);

        // Back-pressure
        tick(); stop_fetch = 1'b1; #2;
        chk1 ("stop_no_req", imem_req, 1'b0);
        chk1 ("stop_push_inflight", write_fifo, 1'b1);
        chk32("stop_push_pc0", fetch_instr_pc[31:0], 32'h18);
        tick(); #2;
        chk1("stall_no_req", imem_req, 1'b0);
        chk1("stall_no_push", write_fifo, 1'b0);
        tick(); stop_fetch = 1'b0; #2;
        chk1 ("resume_req", imem_req, 1'b1);
        chk32("resume_addr", imem_addr, 32'h20);
        tick(); #2;
        chk32("resume_push_pc0", fetch_instr_pc[31:0], 32'h20);

        // Jump with a response in flight
        tick(); jump = 1'b1; jump_addr = 32'h100; #2;
        chk1("jmp_squash", write_fifo, 1'b0);
        chk1("jmp_no_req", imem_req, 1'b0);
        chk1("jmp_no_acc_yet", jump_accept, 1'b0);
        tick(); #2;
        chk1 ("jmp_accept", jump_accept, 1'b1);
        chk32("jmp_addr", imem_addr, 32'h100);
        chk1 ("jmp_req", imem_req, 1'b1);
        tick(); jump = 1'b0; #2;
        chk1 ("jmp_acc_pulse", jump_accept, 1'b0);
        chk32("jmp_push_pc0", fetch_instr_pc[31:0], 32'h100);
        mask = 64'hDEAD_0000_0000_BEEF;

        // Jump to the upper word of a bundle
        tick(); jump = 1'b1; jump_addr = 32'h204; #2;
        chk1("odd_squash", write_fifo, 1'b0);
        tick(); jump = 1'b0; #2;
        chk32("odd_addr", imem_addr, 32'h200);
        tick(); #2;
        chk32("odd_pc0",    fetch_instr_pc[31:0],   32'h200);
        chk32("odd_instr0", fetch_instr_pc[63:32],  NOP);
        chk32("odd_pc1",    fetch_instr_pc[95:64],  32'h204);
        chk32("odd_instr1", fetch_instr_pc[127:96], 32'hDEAD_0204);

        // Address wrap
        tick(); jump = 1'b1; jump_addr = 32'hFFFF_FFF0;
        tick(); jump = 1'b0; #2; chk32("wrap_a0", imem_addr, 32'hFFFF_FFF0);
        tick(); #2; chk32("wrap_a1", imem_addr, 32'hFFFF_FFF8);
        tick(); #2;
        chk32("wrap_addr", imem_addr, 32'h0);
        chk32("wrap_pc1", fetch_instr_pc[95:64], 32'hFFFF_FFFC);
        tick(); #2;
        chk32("wrap_push_pc0", fetch_instr_pc[31:0], 32'h0);
        chk32("wrap_push_pc1", fetch_instr_pc[95:64], 32'h4);

        // Jump while stalled, then reset mid-stream
        tick(); stop_fetch = 1'b1; #2;
        chk32("stall2_push_pc0", fetch_instr_pc[31:0], 32'h8);
        tick(); jump = 1'b1; jump_addr = 32'h300; #2;
        chk1("sj_no_req", imem_req, 1'b0);
        tick(); #2;
        chk1("sj_accept", jump_accept, 1'b1);
        chk1("sj_no_req2", imem_req, 1'b0);
        tick(); jump = 1'b0; #2;
        chk1("sj_still_stalled", imem_req, 1'b0);
        tick(); stop_fetch = 1'b0; #2;
        chk32("sj_resume_addr", imem_addr, 32'h300);
        tick(); #2;
        chk32("sj_push_pc0", fetch_instr_pc[31:0], 32'h300);
        tick(); rst_n = 1'b0; #2;
        chk1  ("mr_no_push", write_fifo, 1'b0);
        chk1  ("mr_no_req", imem_req, 1'b0);
        chk32 ("mr_addr", imem_addr, RST_PC);
        chk128("mr_word", fetch_instr_pc, '0);
        tick(); rst_n = 1'b1; #2;
        chk1("mr_idle", imem_req, 1'b0);
        chk1("mr_idle_no_push", write_fifo, 1'b0);
        tick(); #2;
        chk32("mr_restart_addr", imem_addr, RST_PC);
        chk1 ("mr_restart_req", imem_req, 1'b1);

        // Mixed stall / jump sequence, checked by the model alone
        pat = '{2'b00, 2'b01, 2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b00,
                2'b10, 2'b11, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00};
        for (int i = 0; i < 16; i++) begin
            tick();
            stop_fetch = pat[i][1];
            jump       = pat[i][0];
            jump_addr  = 32'h400 + 32'(i) * 32'd12;
        end
        tick(); jump = 1'b0; stop_fetch = 1'b0;
        repeat (4) tick();
        @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
